// File: rtl/uart_parse_pkg.sv
// Shared types and helpers for the UART frame parser.
// Holds the parser state encoding, hex-ASCII helpers and counter sizing.
package uart_parse_pkg;

    typedef enum logic [1:0] {
        HUNT,
        SKIP,
        FIELD,
        SEP
    } parse_state_t;

    // Width of a counter that must hold 0..n-1, never narrower than 1 bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic bit is_hex_ascii(input logic [7:0] b);
        return ((b >= 8'h30) && (b <= 8'h39)) ||
               ((b >= 8'h41) && (b <= 8'h46)) ||
               ((b >= 8'h61) && (b <= 8'h66));
    endfunction

    // Only meaningful for bytes accepted by is_hex_ascii.
    function automatic logic [3:0] hex_ascii_to_nibble(input logic [7:0] b);
        logic [7:0] v;
        if (b <= 8'h39)
            v = b - 8'h30;
        else if (b <= 8'h46)
            v = b - 8'h37;
        else
            v = b - 8'h57;
        return v[3:0];
    endfunction

endpackage

// File: rtl/uart_frame_parser_pdet.sv
// Preamble window: shift register of the last PRE_LEN bytes plus compare.
// match looks at the window as it would be after shifting in byte_in.
module uart_preamble_det
    import uart_parse_pkg::*;
#(
    parameter int                   PRE_LEN  = 5,
    parameter logic [PRE_LEN*8-1:0] PREAMBLE = "%NOTI"
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       brcv_tick,
    input  logic [7:0] byte_in,
    input  logic       clr,
    output logic       match
);

    localparam int W = PRE_LEN * 8;

    logic [W-1:0] win_q;
    logic [W-1:0] win_d;

    generate
        if (PRE_LEN == 1) begin : g_one
            assign win_d = byte_in;
        end else begin : g_multi
            assign win_d = {win_q[W-9:0], byte_in};
        end
    endgenerate

    assign match = (win_d == PREAMBLE);

    // Shift on each byte; a lock empties the window so it restarts clean.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            win_q <= '0;
        else if (clr)
            win_q <= '0;
        else if (brcv_tick)
            win_q <= win_d;
    end

endmodule

// File: rtl/uart_frame_parser.sv
// UART frame parser: preamble hunt, header skip, hex field capture.
// Build option UART_PARSE_TIMEOUT_EN adds an inter-byte timeout abort.
module uart_frame_parser
    import uart_parse_pkg::*;
#(
    parameter int                   PRE_LEN     = 5,
    parameter logic [PRE_LEN*8-1:0] PREAMBLE    = "%NOTI",
    parameter int                   SKIP_LEN    = 6,
    parameter int                   NUM_FIELDS  = 3,
    parameter int                   DIGITS      = 8,
    parameter int                   SEP_LEN     = 1,
    parameter int                   TIMEOUT_CYC = 1_000_000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           brcv_tick,
    input  logic [7:0]                     byte_in,
    output logic                           drdy_tick,
    output logic                           err_tick,
    output logic [NUM_FIELDS*DIGITS*8-1:0] ascii_out,
    output logic [NUM_FIELDS*DIGITS*4-1:0] hex_out,
    output logic                           busy
);

    localparam int SKW = cnt_w(SKIP_LEN);
    localparam int DGW = cnt_w(DIGITS);
    localparam int FDW = cnt_w(NUM_FIELDS);
    localparam int SPW = cnt_w(SEP_LEN);

    parse_state_t   state_q;
    logic [SKW-1:0] skip_q;
    logic [DGW-1:0] dig_q;
    logic [FDW-1:0] fld_q;
    logic [SPW-1:0] sep_q;
    logic           frame_err_q;

    // Index 0 is leftmost, so field 0 / first character land in the MSBs.
    logic [0:NUM_FIELDS-1][0:DIGITS-1][7:0] cap_a_q, cap_a_d;
    logic [0:NUM_FIELDS-1][0:DIGITS-1][3:0] cap_h_q, cap_h_d;

    logic bad_d;
    logic last_dig;
    logic last_fld;
    logic in_hunt;
    logic match;
    logic timeout_hit;

    assign in_hunt = (state_q == HUNT);

    uart_preamble_det #(
        .PRE_LEN  (PRE_LEN),
        .PREAMBLE (PREAMBLE)
    ) u_pdet (
        .clk       (clk),
        .reset     (reset),
        .brcv_tick (brcv_tick & in_hunt),
        .byte_in   (byte_in),
        .clr       (brcv_tick & in_hunt & match),
        .match     (match)
    );

`ifdef UART_PARSE_TIMEOUT_EN
    localparam int TOW = cnt_w(TIMEOUT_CYC);

    logic [TOW-1:0] to_q;

    // A byte arriving on the expiry cycle takes priority over the abort.
    assign timeout_hit = !in_hunt && !brcv_tick &&
                         (to_q == TOW'(TIMEOUT_CYC - 1));

    // Idle-cycle counter, restarted by every byte and held at 0 in HUNT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            to_q <= '0;
        else if (brcv_tick || in_hunt)
            to_q <= '0;
        else
            to_q <= to_q + 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Buffer contents as they would be with the current byte captured.
    always_comb begin
        cap_a_d = cap_a_q;
        cap_h_d = cap_h_q;
        cap_a_d[fld_q][dig_q] = byte_in;
        cap_h_d[fld_q][dig_q] = hex_ascii_to_nibble(byte_in);
        bad_d    = frame_err_q | !is_hex_ascii(byte_in);
        last_dig = (dig_q == DGW'(DIGITS - 1));
        last_fld = (fld_q == FDW'(NUM_FIELDS - 1));
    end

    // Frame sequencer with registered pulses, busy and result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= HUNT;
            skip_q      <= '0;
            dig_q       <= '0;
            fld_q       <= '0;
            sep_q       <= '0;
            frame_err_q <= 1'b0;
            cap_a_q     <= '0;
            cap_h_q     <= '0;
            drdy_tick   <= 1'b0;
            err_tick    <= 1'b0;
            ascii_out   <= '0;
            hex_out     <= '0;
            busy        <= 1'b0;
        end else begin
            drdy_tick <= 1'b0;
            err_tick  <= 1'b0;
            if (timeout_hit) begin
                state_q     <= HUNT;
                busy        <= 1'b0;
                skip_q      <= '0;
                dig_q       <= '0;
                fld_q       <= '0;
                sep_q       <= '0;
                frame_err_q <= 1'b0;
                cap_a_q     <= '0;
                cap_h_q     <= '0;
                err_tick    <= 1'b1;
            end else if (brcv_tick) begin
                unique case (state_q)
                    HUNT: begin
                        if (match) begin
                            busy    <= 1'b1;
                            state_q <= (SKIP_LEN == 0) ? FIELD : SKIP;
                        end
                    end
                    SKIP: begin
                        if (skip_q == SKW'(SKIP_LEN - 1)) begin
                            skip_q  <= '0;
                            state_q <= FIELD;
                        end else begin
                            skip_q <= skip_q + 1'b1;
                        end
                    end
                    FIELD: begin
                        if (!last_dig) begin
                            dig_q       <= dig_q + 1'b1;
                            cap_a_q     <= cap_a_d;
                            cap_h_q     <= cap_h_d;
                            frame_err_q <= bad_d;
                        end else if (!last_fld) begin
                            dig_q       <= '0;
                            fld_q       <= fld_q + 1'b1;
                            cap_a_q     <= cap_a_d;
                            cap_h_q     <= cap_h_d;
                            frame_err_q <= bad_d;
                            state_q     <= (SEP_LEN == 0) ? FIELD : SEP;
                        end else begin
                            state_q     <= HUNT;
                            busy        <= 1'b0;
                            dig_q       <= '0;
                            fld_q       <= '0;
                            frame_err_q <= 1'b0;
                            cap_a_q     <= '0;
                            cap_h_q     <= '0;
                            if (bad_d) begin
                                err_tick <= 1'b1;
                            end else begin
                                drdy_tick <= 1'b1;
                                ascii_out <= cap_a_d;
                                hex_out   <= cap_h_d;
                            end
                        end
                    end
                    SEP: begin
                        if (sep_q == SPW'(SEP_LEN - 1)) begin
                            sep_q   <= '0;
                            state_q <= FIELD;
                        end else begin
                            sep_q <= sep_q + 1'b1;
                        end
                    end
                    default: state_q <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser (default and small-frame builds).
// Define UART_PARSE_TIMEOUT_EN to include the timeout scenarios.
module tb_uart_frame_parser;

    typedef struct {
        bit          is_err;
        logic [191:0] a;
        logic [95:0]  h;
        int unsigned  at;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         brcv_tick;
    logic         tick2;
    logic [7:0]   byte_in;
    logic         drdy_tick, err_tick, busy;
    logic [191:0] ascii_out;
    logic [95:0]  hex_out;
    logic         drdy2, err2, busy2;
    logic [63:0]  ascii2;
    logic [31:0]  hex2;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        q1[$];
    exp_t        q2[$];
    logic [191:0] last_a = '0;
    logic [95:0]  last_h = '0;

    uart_frame_parser #(
        .TIMEOUT_CYC (100)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .brcv_tick (brcv_tick),
        .byte_in   (byte_in),
        .drdy_tick (drdy_tick),
        .err_tick  (err_tick),
        .ascii_out (ascii_out),
        .hex_out   (hex_out),
        .busy      (busy)
    );

    uart_frame_parser #(
        .PRE_LEN    (2),
        .PREAMBLE   (16'h2441),
        .SKIP_LEN   (0),
        .NUM_FIELDS (2),
        .DIGITS     (4),
        .SEP_LEN    (0)
    ) dut2 (
        .clk       (clk),
        .reset     (reset),
        .brcv_tick (tick2),
        .byte_in   (byte_in),
        .drdy_tick (drdy2),
        .err_tick  (err2),
        .ascii_out (ascii2),
        .hex_out   (hex2),
        .busy      (busy2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [191:0] act,
                       input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor for the default-parameter parser.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            last_a = '0;
            last_h = '0;
        end else if (drdy_tick || err_tick) begin
            if (q1.size() == 0) begin
                chk("unexpected_pulse", {drdy_tick, err_tick}, 0);
            end else begin
                e = q1.pop_front();
                chk("pulse_kind", {drdy_tick, err_tick},
                    e.is_err ? 192'd1 : 192'd2);
                chk("pulse_cycle", cyc, e.at);
                chk("busy_at_pulse", busy, 0);
                if (!e.is_err) begin
                    last_a = e.a;
                    last_h = e.h;
                end
                chk("ascii_out", ascii_out, last_a);
                chk("hex_out", hex_out, last_h);
            end
        end
    end

    // Monitor for the small-frame parser.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && (drdy2 || err2)) begin
            if (q2.size() == 0) begin
                chk("unexpected_pulse2", {drdy2, err2}, 0);
            end else begin
                e = q2.pop_front();
                chk("pulse_kind2", {drdy2, err2}, e.is_err ? 192'd1 : 192'd2);
                chk("pulse_cycle2", cyc, e.at);
                chk("ascii_out2", ascii2, e.a[63:0]);
                chk("hex_out2", hex2, e.h[31:0]);
            end
        end
    end

    task automatic send(input logic [7:0] b, input bit to2);
        @(negedge clk);
        byte_in = b;
        if (to2)
            tick2 = 1'b1;
        else
            brcv_tick = 1'b1;
        @(posedge clk);
        #1;
        brcv_tick = 1'b0;
        tick2     = 1'b0;
    endtask

    task automatic send_str(input string s, input bit to2);
        for (int i = 0; i < s.len(); i++)
            send(s[i], to2);
    endtask

    task automatic expect1(input bit is_err, input logic [191:0] a,
                           input logic [95:0] h, input int unsigned at);
        exp_t e;
        e.is_err = is_err;
        e.a      = a;
        e.h      = h;
        e.at     = at;
        q1.push_back(e);
    endtask

    logic [191:0] a1, a2;
    logic [95:0]  h1, h2;

    initial begin
        exp_t e;
        a1 = "0000ABCDFFFF00121234abcd";
        h1 = 96'h0000ABCD_FFFF0012_1234ABCD;
        a2 = "DEADbeef0123456789abcdef";
        h2 = 96'hDEADBEEF_01234567_89ABCDEF;
        reset     = 1'b1;
        brcv_tick = 1'b0;
        tick2     = 1'b0;
        byte_in   = 8'h00;
        #12;
        chk("rst_ascii", ascii_out, 0);
        chk("rst_hex", hex_out, 0);
        chk("rst_flags", {drdy_tick, err_tick, busy}, 0);
        @(negedge clk);
        #2 reset = 1'b0;

        // Good frame.
        send_str("%NOTIjunk!!0000ABCD,FFFF0012,1234abcd", 1'b0);
        expect1(1'b0, a1, h1, cyc);

        // Bad digit in field 1, then a good frame straight after.
        send_str("%NOTIjunk!!0000ABCD,FFFFG012,1234abcd", 1'b0);
        expect1(1'b1, '0, '0, cyc);
        send_str("%NOTIjunk!!DEADbeef;01234567;89abcdef", 1'b0);
        expect1(1'b0, a2, h2, cyc);

        // Near-miss preamble, then overlapping one; preamble in header is data.
        send_str("%NOTX", 1'b0);
        @(negedge clk);
        chk("nolock_busy", busy, 0);
        send_str("%N%NOTI%NOTI!0000ABCD,FFFF0012,1234abcd", 1'b0);
        expect1(1'b0, a1, h1, cyc);

        // Reset in the middle of field 0.
        send_str("%NOTIjunk!!000", 1'b0);
        @(negedge clk);
        chk("midframe_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_ascii", ascii_out, 0);
        chk("midrst_hex", hex_out, 0);
        chk("midrst_flags", {drdy_tick, err_tick, busy}, 0);
        @(negedge clk);
        #2 reset = 1'b0;
        send_str("%NOTIjunk!!DEADbeef;01234567;89abcdef", 1'b0);
        expect1(1'b0, a2, h2, cyc);

        // Small frame on the second instance.
        send_str("$A12EF00ff", 1'b1);
        e.is_err = 1'b0;
        e.a      = {128'h0, 64'h3132_4546_3030_6666};
        e.h      = {64'h0, 32'h12EF00FF};
        e.at     = cyc;
        q2.push_back(e);

`ifdef UART_PARSE_TIMEOUT_EN
        // Stall mid-field: abort exactly 100 cycles after the last byte.
        send_str("%NOTIjunk!!0000A", 1'b0);
        expect1(1'b1, '0, '0, cyc + 100);
        repeat (110) @(posedge clk);
        #1;
        chk("timeout_busy", busy, 0);
        // Byte landing on the expiry cycle keeps the frame alive.
        send_str("%NOTIjunk!!0000AB", 1'b0);
        repeat (99) @(posedge clk);
        send_str("CD,FFFF0012,1234abcd", 1'b0);
        expect1(1'b0, a1, h1, cyc);
`endif

        repeat (5) @(negedge clk);
        chk("pending_q1", q1.size(), 0);
        chk("pending_q2", q2.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
- Parametrised successor to the single-field PMOD ASCII parser.
- Hunts a configurable preamble in the UART byte stream, skips a fixed header, then captures NUM_FIELDS hex-ASCII fields of DIGITS characters each, separated by SEP_LEN bytes.
- Validates every digit and presents both the raw ASCII and the decoded binary values to the SweRVolf wishbone-side registers.
- Sits between uart_rx (byte + tick) and the accelerometer register bank.

Parameters:
- PRE_LEN, 5, preamble length in bytes (1..8).
- PREAMBLE, "%NOTI", preamble string; PRE_LEN*8 bits, first-received byte in the MSBs.
- SKIP_LEN, 6, bytes discarded after preamble (0..15).
- NUM_FIELDS, 3, number of hex fields per frame (1..4).
- DIGITS, 8, hex characters per field (1..8).
- SEP_LEN, 1, bytes discarded between fields; not applied after the last field (0..3).
- TIMEOUT_CYC, 1_000_000, inter-byte timeout in clk cycles (optional feature only).

Ports:
- clk  in  1  system clock.
- reset  in  1  reset.
- brcv_tick  in  1  one-cycle strobe: byte_in valid.
- byte_in  in  8  received byte.
- drdy_tick  out  1  one-cycle pulse: new valid frame on outputs.
- err_tick  out  1  one-cycle pulse: frame aborted because of an invalid digit or timeout.
- ascii_out  out  NUM_FIELDS*DIGITS*8  raw characters; field 0 in the MSBs, first character in the MSB of its field.
- hex_out  out  NUM_FIELDS*DIGITS*4  decoded nibbles, same ordering as ascii_out.
- busy  out  1  high in any state other than HUNT.

Behaviour:
- Interface: reset is asynchronous, active-high; clock is clk.
- Reset values: all outputs 0; state HUNT; all counters and windows 0.
- All outputs are registered.
- ascii_out and hex_out update only on the same edge that raises drdy_tick, and hold their value until the next valid frame.
- State machine HUNT -> SKIP -> FIELD -> SEP -> FIELD ... -> HUNT. States are evaluated only on brcv_tick unless stated otherwise.
- HUNT:
  - Each tick shifts byte_in into a PRE_LEN-byte window.
  - If the shifted window value equals PREAMBLE, clear the window on the same edge and move to SKIP. If SKIP_LEN==0, move straight to FIELD.
  - A byte that completes the preamble is never counted as a skip byte.
- SKIP: count ticks; on the SKIP_LEN-th tick go to FIELD with the counter cleared.
- FIELD:
  - Each tick stores the byte into a capture buffer at position [field_idx][digit_idx] and stores its decoded nibble alongside.
  - Valid digits are '0'-'9', 'A'-'F' and 'a'-'f'.
  - Any other byte sets a sticky frame_err flag. Capture continues, so byte alignment is preserved.
  - On the last digit of a field:
    - If more fields remain, go to SEP. If SEP_LEN==0, go straight to FIELD with the next field index.
    - If this is the final field, go to HUNT. On the next edge pulse drdy_tick and update the outputs if frame_err==0; otherwise pulse err_tick and leave the outputs untouched.
  - Latency: drdy_tick is asserted exactly 1 cycle after the brcv_tick carrying the final digit.
- SEP: discard SEP_LEN ticks. Contents are not checked. Then return to FIELD.
- frame_err, the capture buffer and all counters clear on entry to HUNT.
- If a preamble appears inside a frame, it is treated as data. Resynchronisation happens only after the frame completes.
- A brcv_tick that arrives on the same cycle as a drdy_tick or err_tick pulse is processed normally in HUNT.
- Counter widths come from $clog2 of each parameter, with a minimum of 1 bit.
- Asserting reset mid-frame returns immediately to HUNT. Outputs go to 0 and no pulse is emitted.

Optional Feature:
- Macro: UART_PARSE_TIMEOUT_EN.
- Defined:
  - A cycle counter resets on every brcv_tick.
  - If the counter reaches TIMEOUT_CYC while not in HUNT, pulse err_tick for 1 cycle and go to HUNT. Outputs are unchanged.
  - If brcv_tick coincides with the timeout cycle, the byte wins and the timeout is discarded.
- Undefined: no counter is built; the parser waits indefinitely for bytes.

Decomposition:
- Package uart_parse_pkg:
  - parse_state_t enum {HUNT, SKIP, FIELD, SEP}.
  - Function is_hex_ascii(byte) -> bit.
  - Function hex_ascii_to_nibble(byte) -> 4-bit.
  - Localparam helpers for the counter widths.
- One sub-module, uart_preamble_det: PRE_LEN window plus compare.
  - Inputs: clk, reset, brcv_tick, byte_in, clr.
  - Output: match, combinational from the shifted window.

Test Plan:
1. "%NOTI", 6 junk bytes, then "0000ABCD", ",", "FFFF0012", ",", "1234abcd" with defaults -> 1 cycle after the last tick: drdy_tick=1 and hex_out=0x0000ABCD_FFFF0012_1234ABCD; ascii_out matches the characters received.
2. Same frame with the digit 'G' in field 1 -> err_tick pulses once, drdy_tick stays 0, outputs keep their previous value, and a following good frame is accepted.
3. Stream "%N%NOTI" followed by a valid frame -> overlapping preamble detected and frame accepted. Stream "%NOT" + "X" -> no lock and busy stays 0.
4. Reset asserted after 3 digits of field 0 -> outputs 0, busy=0, no pulse. A subsequent full frame decodes correctly.
5. Parameter override PRE_LEN=2 "$A", SKIP_LEN=0, SEP_LEN=0, NUM_FIELDS=2, DIGITS=4 with stream "$A12EF00ff" -> hex_out=0x12EF00FF.
6. With UART_PARSE_TIMEOUT_EN and TIMEOUT_CYC=100: stop bytes mid-field -> err_tick on cycle 100 after the last tick, busy drops. A byte arriving on exactly cycle 100 -> no timeout.
